// File: rtl/cw_key_sidetone.sv
// CW key conditioning and sidetone: paddle sync/debounce, key/PTT-hang FSM,
// square-wave sidetone while keyed.

// Per-paddle conditioning: two-flop synchronizer, invert, ms-tick debounce.
module cw_deb #(
  parameter int DEB_MS = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic ms_tick,
  output logic out
);
  localparam int CW = $clog2(DEB_MS + 2);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          lvl;

  assign lvl = ~sync[1];

  // Synchronizer resets to the released (high) raw level.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], raw};

  // The first tick after a change starts the window; DEB_MS further ticks
  // with no change are needed before the output follows.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (lvl == out) begin
      cnt <= '0;
    end else if (ms_tick) begin
      if (cnt == CW'(DEB_MS)) begin
        out <= lvl;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
endmodule

module cw_key_sidetone #(
  parameter int TICK_DIV   = 76800,
  parameter int TONE_PRESC = 96,
  parameter int DEB_MS     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_cwl,
  input  logic        io_cwr,
  input  logic        cw_enable,
  input  logic        tx_inhibit,
  input  logic        sidetone_en,
  input  logic [11:0] tone_half,
  input  logic [9:0]  hang_ms,
  output logic        pi_cwl,
  output logic        pi_cwr,
  output logic        cw_keydown,
  output logic        io_cw_on,
  output logic        io_sidetone
);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int PW = $clog2(TONE_PRESC + 1);

  typedef enum logic [1:0] {IDLE, KEYED, HANG} st_t;

  logic [TW-1:0] ms_cnt;
  logic [PW-1:0] tn_cnt;
  logic          ms_tick, tone_tick;
  logic [1:0]    raw, deb;
  st_t           st, nxt;
  logic [9:0]    hang_cnt;
  logic          hang_zero;
  logic          force_idle, tone_on;
  logic [11:0]   tcnt, th;

  assign raw    = {io_cwr, io_cwl};
  assign pi_cwl = deb[0];
  assign pi_cwr = deb[1];

  for (genvar i = 0; i < 2; i++) begin : g_deb
    cw_deb #(.DEB_MS(DEB_MS)) u_deb (
      .clk(clk), .rst_n(rst_n), .raw(raw[i]), .ms_tick(ms_tick), .out(deb[i])
    );
  end

  assign ms_tick   = (ms_cnt == TW'(TICK_DIV - 1));
  assign tone_tick = (tn_cnt == PW'(TONE_PRESC - 1));

  // Free-running ms and tone prescalers.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ms_cnt <= '0;
      tn_cnt <= '0;
    end else begin
      ms_cnt <= ms_tick   ? '0 : ms_cnt + 1'b1;
      tn_cnt <= tone_tick ? '0 : tn_cnt + 1'b1;
    end

  assign force_idle = tx_inhibit | ~cw_enable;

  // Key FSM state register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else        st <= nxt;

  // Next state; inhibit/disable override any key-down.
  always_comb begin
    nxt = st;
    if (force_idle) nxt = IDLE;
    else begin
      case (st)
        IDLE:  if (pi_cwl) nxt = KEYED;
        KEYED: if (!pi_cwl) nxt = HANG;
        HANG:  if (pi_cwl) nxt = KEYED;
               else if (hang_cnt == 10'd0 && (ms_tick || hang_zero)) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // Hang counter: loaded on key-up, counts down on ms ticks.
  // hang_zero lets a zero hang time leave on the next clk without a tick.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hang_cnt  <= '0;
      hang_zero <= 1'b0;
    end else if (st == KEYED && nxt == HANG) begin
      hang_cnt  <= hang_ms;
      hang_zero <= (hang_ms == 10'd0);
    end else if (st == HANG && ms_tick && hang_cnt != 10'd0) begin
      hang_cnt <= hang_cnt - 1'b1;
    end

  // Registered key outputs; force_idle drops them on the very next clk.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cw_keydown <= 1'b0;
      io_cw_on   <= 1'b0;
    end else begin
      cw_keydown <= (st == KEYED) && !force_idle;
      io_cw_on   <= (st == KEYED || st == HANG) && !force_idle;
    end

  assign tone_on = (st == KEYED) && sidetone_en && !force_idle;
  assign th      = (tone_half == 12'd0) ? 12'd1 : tone_half;

  // Sidetone half-period counter; >= keeps a live shrink of tone_half safe.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt        <= '0;
      io_sidetone <= 1'b0;
    end else if (!tone_on) begin
      tcnt        <= '0;
      io_sidetone <= 1'b0;
    end else if (tone_tick) begin
      if (tcnt >= th - 12'd1) begin
        tcnt        <= '0;
        io_sidetone <= ~io_sidetone;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
endmodule
